// File: rtl/chime_alarm_gen.sv
// Hourly chime and multi-channel alarm buzzer generator.
// On the last second of each hour it sounds one strike per upcoming hour.
// Alarm channels take priority over the chime and can be snoozed.
module chime_alarm_gen #(
    parameter int NUM_ALARMS  = 2,
    parameter int HALF_CYC    = 4,
    parameter int H12         = 0,
    parameter int ALARM_SECS  = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic                  cp,
    input  logic                  rst,
    input  logic [7:0]            hours,
    input  logic [7:0]            minte,
    input  logic [7:0]            secd,
    input  logic                  sec_tick,
    input  logic                  chime_en,
    input  logic                  al_we,
    input  logic [1:0]            al_sel,
    input  logic [7:0]            al_hour,
    input  logic [7:0]            al_min,
    input  logic [NUM_ALARMS-1:0] al_en,
    input  logic                  snooze,
    output logic                  ring,
    output logic                  busy,
    output logic [NUM_ALARMS-1:0] al_active
);

    localparam int CW   = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1;
    localparam int SMAX = (ALARM_SECS > SNOOZE_SECS) ? ALARM_SECS : SNOOZE_SECS;
    localparam int SW   = $clog2(SMAX + 1);
    localparam logic [CW-1:0] CYC_LAST   = CW'(HALF_CYC - 1);
    localparam logic [SW-1:0] ALARM_LAST = SW'(ALARM_SECS - 1);
    localparam logic [SW-1:0] SNZ_LAST   = SW'(SNOOZE_SECS - 1);

    typedef enum logic [2:0] {IDLE, CH_HI, CH_LO, ALARM, SNOOZE} state_t;

    state_t                  state_q, state_d;
    logic [4:0]              strk_q, strk_d;
    logic [CW-1:0]           cyc_q, cyc_d;
    logic [SW-1:0]           sec_q, sec_d;
    logic                    phase_q, phase_d;
    logic [NUM_ALARMS-1:0]   act_q, act_d;
    logic [7:0]              hr_q [NUM_ALARMS];
    logic [7:0]              mn_q [NUM_ALARMS];

    logic [NUM_ALARMS-1:0]   match_oh;
    logic                    any_match;
    logic [7:0]              hr_bin;
    logic                    hr_valid;
    logic [4:0]              hr_next, hr_mod, strikes_init;
    logic                    chime_trig, act_lost, cyc_wrap;

    // Alarm time registers; a write to a channel that does not exist matches no k.
    always_ff @(posedge cp) begin
        if (rst) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                hr_q[k] <= 8'h00;
                mn_q[k] <= 8'h00;
            end
        end else if (al_we) begin
            for (int k = 0; k < NUM_ALARMS; k++) begin
                if (al_sel == 2'(k)) begin
                    hr_q[k] <= al_hour;
                    mn_q[k] <= al_min;
                end
            end
        end
    end

    // Alarm match with lowest-index priority (descending loop, last hit wins).
    always_comb begin
        match_oh  = '0;
        any_match = 1'b0;
        for (int k = NUM_ALARMS - 1; k >= 0; k--) begin
            if (sec_tick && al_en[k] && hours == hr_q[k] && minte == mn_q[k]
                && secd == 8'h00) begin
                match_oh    = '0;
                match_oh[k] = 1'b1;
                any_match   = 1'b1;
            end
        end
    end

    // Strike count from the upcoming hour; invalid BCD hours suppress the trigger.
    always_comb begin
        hr_bin   = {4'd0, hours[7:4]} * 8'd10 + {4'd0, hours[3:0]};
        hr_valid = (hours[7:4] <= 4'd2) && (hours[3:0] <= 4'd9) && (hr_bin <= 8'd23);
        hr_next  = (hr_bin == 8'd23) ? 5'd0 : hr_bin[4:0] + 5'd1;
        hr_mod   = (hr_next >= 5'd12) ? hr_next - 5'd12 : hr_next;
        if (H12 != 0) begin
            strikes_init = (hr_mod == 5'd0) ? 5'd12 : hr_mod;
        end else begin
            strikes_init = (hr_next == 5'd0) ? 5'd24 : hr_next;
        end
        chime_trig = sec_tick && chime_en && minte == 8'h59 && secd == 8'h59 && hr_valid;
    end

    // Next-state logic and outputs.
    always_comb begin
        state_d  = state_q;
        strk_d   = strk_q;
        cyc_d    = cyc_q;
        sec_d    = sec_q;
        phase_d  = phase_q;
        act_d    = act_q;
        act_lost = |(act_q & ~al_en);
        cyc_wrap = (cyc_q == CYC_LAST);

        unique case (state_q)
            IDLE, CH_HI, CH_LO: begin
                if (any_match) begin
                    // Alarm preempts any chime in progress.
                    state_d = ALARM;
                    act_d   = match_oh;
                    sec_d   = '0;
                    cyc_d   = '0;
                    phase_d = 1'b1;
                end else if (state_q == IDLE) begin
                    if (chime_trig) begin
                        state_d = CH_HI;
                        strk_d  = strikes_init;
                        cyc_d   = '0;
                    end
                end else begin
                    cyc_d = cyc_wrap ? '0 : cyc_q + CW'(1);
                    if (cyc_wrap) begin
                        if (state_q == CH_HI) begin
                            state_d = CH_LO;
                        end else if (strk_q <= 5'd1) begin
                            state_d = IDLE;
                        end else begin
                            state_d = CH_HI;
                            strk_d  = strk_q - 5'd1;
                        end
                    end
                end
            end
            ALARM: begin
                if (act_lost) begin
                    state_d = IDLE;
                    act_d   = '0;
                end else if (snooze) begin
                    state_d = SNOOZE;
                    sec_d   = '0;
                    phase_d = 1'b0;
                end else if (sec_tick && sec_q == ALARM_LAST) begin
                    state_d = IDLE;
                    act_d   = '0;
                end else begin
                    cyc_d = cyc_wrap ? '0 : cyc_q + CW'(1);
                    if (cyc_wrap) phase_d = ~phase_q;
                    if (sec_tick) sec_d = sec_q + SW'(1);
                end
            end
            SNOOZE: begin
                if (act_lost) begin
                    state_d = IDLE;
                    act_d   = '0;
                end else if (sec_tick) begin
                    if (sec_q == SNZ_LAST) begin
                        state_d = ALARM;
                        sec_d   = '0;
                        cyc_d   = '0;
                        phase_d = 1'b1;
                    end else begin
                        sec_d = sec_q + SW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        ring      = (state_q == CH_HI) || (state_q == ALARM && phase_q);
        busy      = (state_q != IDLE);
        al_active = act_q;
    end

    // State and counter registers.
    always_ff @(posedge cp) begin
        if (rst) begin
            state_q <= IDLE;
            strk_q  <= '0;
            cyc_q   <= '0;
            sec_q   <= '0;
            phase_q <= 1'b0;
            act_q   <= '0;
        end else begin
            state_q <= state_d;
            strk_q  <= strk_d;
            cyc_q   <= cyc_d;
            sec_q   <= sec_d;
            phase_q <= phase_d;
            act_q   <= act_d;
        end
    end

endmodule
